// File: rtl/pipemem.sv
// pipemem: MEM stage of the 5-stage RISC-V pipeline.
//
// This stage sits between the EX/MEM register and the MEM/WB register.
// It issues loads and stores to data memory over a req/ack handshake and
// builds the byte enables and the lane-shifted store data. It also
// sign/zero-extends load data and owns the MEM/WB register. The wb_data
// output of that register doubles as the MEM_WB forwarding value for EX.
// While an access is outstanding the stage stalls upstream. It raises
// timeout exceptions and, optionally, misaligned-access exceptions.
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned word or
// half accesses. When it is undefined, the low address bits are ignored and
// the access proceeds on the aligned lanes.
//
// Parameter:
//   ACK_TIMEOUT  : cycles allowed in WAIT before the access is abandoned (1..255)
// Ports:
//   clk, rstn                     : clock (rising edge), async active-low reset
//   in_valid .. in_WDSel          : EX/MEM slot contents
//   dm_req/dm_we/dm_addr/dm_be/dm_wdata : data memory request side
//   dm_rdata, dm_ack              : data memory response side
//   stall_mem                     : freeze PC, IF/ID, ID/EX and EX/MEM
//   wb_valid/wb_RegWrite/wb_rd/wb_data : MEM/WB register
//   mem_exc/mem_exc_cause/mem_exc_pc   : registered one-cycle exception report
module pipemem #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    input  logic [31:0] in_aluout,
    input  logic [31:0] in_store,
    input  logic [31:0] in_pc,
    input  logic        in_MemRead,
    input  logic        in_MemWrite,
    input  logic [2:0]  in_DMType,
    input  logic        in_RegWrite,
    input  logic [4:0]  in_rd,
    input  logic [1:0]  in_WDSel,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        stall_mem,
    output logic        wb_valid,
    output logic        wb_RegWrite,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        mem_exc,
    output logic [1:0]  mem_exc_cause,
    output logic [31:0] mem_exc_pc
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(ACK_TIMEOUT);

    state_t      state, state_next;
    logic [7:0]  wcnt, wcnt_next;
    logic        memop;
    logic        is_store;
    logic        misaligned_trap;
    logic        abandon;
    logic        exception;
    logic [1:0]  lane;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] wb_mux;

    assign lane     = in_aluout[1:0];
    assign memop    = in_valid & (in_MemRead | in_MemWrite);
    // If both strobes are set, the access is treated as a store.
    assign is_store = in_MemWrite;

`ifdef MEM_MISALIGN_TRAP_EN
    // Word accesses need addr[1:0]==0. Half accesses need addr[0]==0.
    always_comb begin
        misaligned_trap = 1'b0;
        if (memop) begin
            case (in_DMType)
                3'b000:         misaligned_trap = (lane != 2'b00);
                3'b001, 3'b010: misaligned_trap = lane[0];
                default:        misaligned_trap = 1'b0;
            endcase
        end
    end
`else
    assign misaligned_trap = 1'b0;
`endif

    // Give up on the last allowed WAIT cycle if the ack still has not come.
    assign abandon   = (state == S_WAIT) && (wcnt == TIMEOUT_CNT) && !dm_ack;
    assign exception = misaligned_trap | abandon;

    // The request is gated by reset, so it drops as soon as rstn falls.
    assign dm_req    = rstn & memop & ~misaligned_trap & ~abandon;
    assign stall_mem = dm_req & ~dm_ack;
    assign dm_we     = in_valid & is_store;
    assign dm_addr   = {in_aluout[31:2], 2'b00};
    assign dm_wdata  = in_store << {lane, 3'b000};

    // Byte enables. Word and half ignore the low bits they do not need.
    always_comb begin
        dm_be = 4'b1111;
        case (in_DMType)
            3'b001, 3'b010: dm_be = lane[1] ? 4'b1100 : 4'b0011;
            3'b011, 3'b100: dm_be = 4'b0001 << lane;
            default:        dm_be = 4'b1111;
        endcase
    end

    // Load lane selection followed by sign/zero extension.
    always_comb begin
        ld_byte = dm_rdata[7:0];
        case (lane)
            2'b00: ld_byte = dm_rdata[7:0];
            2'b01: ld_byte = dm_rdata[15:8];
            2'b10: ld_byte = dm_rdata[23:16];
            2'b11: ld_byte = dm_rdata[31:24];
            default: ld_byte = dm_rdata[7:0];
        endcase
        ld_half = lane[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (in_DMType)
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_data = {16'h0000, ld_half};
            3'b011:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h000000, ld_byte};
            default: ld_data = dm_rdata;
        endcase
    end

    // Writeback source select for the MEM/WB register.
    always_comb begin
        case (in_WDSel)
            2'b00:   wb_mux = in_aluout;
            2'b01:   wb_mux = ld_data;
            2'b10:   wb_mux = in_pc + 32'd4;
            default: wb_mux = 32'h0000_0000;
        endcase
    end

    // Handshake FSM. It leaves WAIT on an ack, and also when the request
    // disappears because of a timeout.
    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        case (state)
            S_IDLE: begin
                if (dm_req && !dm_ack) begin
                    state_next = S_WAIT;
                    wcnt_next  = 8'd1;
                end
            end
            S_WAIT: begin
                if (!dm_req || dm_ack) begin
                    state_next = S_IDLE;
                    wcnt_next  = 8'd0;
                end else begin
                    wcnt_next = wcnt + 8'd1;
                end
            end
            default: begin
                state_next = S_IDLE;
                wcnt_next  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            wcnt  <= 8'd0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
        end
    end

    // MEM/WB register. Bubbles keep the previous wb_rd and wb_data values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
            wb_rd       <= 5'd0;
            wb_data     <= 32'h0000_0000;
        end else if (in_valid && !stall_mem && !exception) begin
            wb_valid    <= 1'b1;
            wb_RegWrite <= in_RegWrite;
            wb_rd       <= in_rd;
            wb_data     <= wb_mux;
        end else begin
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
        end
    end

    // Exception report. It is registered and held for exactly one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_exc       <= 1'b0;
            mem_exc_cause <= 2'b00;
            mem_exc_pc    <= 32'h0000_0000;
        end else if (exception) begin
            mem_exc       <= 1'b1;
            mem_exc_cause <= abandon ? 2'b11 : (is_store ? 2'b10 : 2'b01);
            mem_exc_pc    <= in_pc;
        end else begin
            mem_exc       <= 1'b0;
            mem_exc_cause <= 2'b00;
            mem_exc_pc    <= 32'h0000_0000;
        end
    end

endmodule

// File: doc/pipemem.md
# pipemem

MEM stage of the 5-stage RISC-V pipeline, between the EX/MEM register and the MEM/WB register. Issues loads and stores to data memory over a req/ack handshake, generates byte enables and store lane data, and sign/zero-extends load data. It holds the MEM/WB register, whose data output is the MEM_WB forwarding value for EX. It also stalls upstream while an access is outstanding and raises misaligned-access and timeout exceptions.

## Interface
- `ACK_TIMEOUT`, default 255: maximum cycles spent in WAIT before the access is abandoned (range 1..255).
- `clk  in  1`: clock, rising edge.
- `rstn  in  1`: asynchronous active-low reset.
- `in_valid  in  1`: EX/MEM slot holds a live instruction.
- `in_aluout  in  32`: ALU result, used as the memory address.
- `in_store  in  32`: forwarded rs2 value to store.
- `in_pc  in  32`: instruction PC.
- `in_MemRead, in_MemWrite  in  1 each`: load / store.
- `in_DMType  in  3`: 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned.
- `in_RegWrite  in  1`: writes the destination register.
- `in_rd  in  5`: destination register.
- `in_WDSel  in  2`: writeback select; 00 ALU, 01 memory, 10 PC+4.
- `dm_req, dm_we  out  1 each`: request / write strobe.
- `dm_addr  out  32`: word-aligned address, bits [1:0] = 00.
- `dm_be  out  4`: byte enables.
- `dm_wdata  out  32`: lane-shifted store data.
- `dm_rdata  in  32`: read data, valid in the ack cycle.
- `dm_ack  in  1`: access complete.
- `stall_mem  out  1`: freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
- `wb_valid, wb_RegWrite  out  1 each`; `wb_rd  out  5`; `wb_data  out  32` (MEM_WB forwarding/writeback value).
- `mem_exc  out  1`: one-cycle exception pulse.
- `mem_exc_cause  out  2`: 01 misaligned load, 10 misaligned store, 11 timeout.
- `mem_exc_pc  out  32`: PC of the faulting instruction.

## Operation
- `memop = in_valid & (in_MemRead | in_MemWrite)`. MemRead and MemWrite are never both set; if they are, the access is treated as a store.
- FSM states are IDLE and WAIT. There is an 8-bit counter `wcnt`.
- `dm_req = memop & ~misaligned_trap & ~abandon`, asserted in both IDLE and WAIT.
- `dm_addr`, `dm_be`, `dm_wdata` and `dm_we` are combinational from the inputs and hold stable while stalled, because upstream is frozen.
- IDLE transitions:
  - `dm_req & dm_ack` → capture into MEM/WB, stay in IDLE.
  - `dm_req & ~dm_ack` → go to WAIT, `wcnt=1`.
- WAIT transitions:
  - `dm_ack` → capture, go to IDLE.
  - Otherwise `wcnt++`.
  - If `wcnt==ACK_TIMEOUT` and no ack → `abandon`: drop `dm_req` that cycle, pulse timeout exception, go to IDLE.
- `stall_mem = dm_req & ~dm_ack`.
- Byte enables:
  - Word: `dm_be=1111`.
  - Half: `0011` or `1100` by addr[1].
  - Byte: `0001 << addr[1:0]`.
- Store data: `dm_wdata = in_store << (8*addr[1:0])`. Unused lanes are don't-care.
- Loads select the lane using addr[1:0], then sign- or zero-extend per DMType.
- `wb_data` mux: WDSel 00 → `in_aluout`; 01 → extended load data; 10 → `in_pc+4`; 11 → 0.
- MEM/WB register capture rules:
  - If `in_valid & ~stall_mem & ~exception`: capture `wb_valid=1`, rd, RegWrite, and the mux output.
  - If `stall_mem`, `in_valid=0`, or an exception fires: capture a bubble (`wb_valid=0`, `wb_RegWrite=0`). `wb_rd` and `wb_data` keep their previous values.
- Non-memory instructions pass through in one cycle with no `dm_req`.

## Timing
- Reset (async, while `rstn=0`): FSM=IDLE, `wcnt=0`, all registered outputs 0 (`wb_*`, `mem_exc*`). `dm_req` goes to 0 with reset because it is gated by reset.
- Latency:
  - Zero-wait memory (ack in the request cycle): result visible on `wb_*` one cycle after the instruction is presented.
  - N wait cycles: stall asserted for N cycles, result visible N+1 cycles after presentation.
- Stores complete identically; they set `wb_valid=1` with `wb_RegWrite` taken from input (0 for stores).
- `mem_exc`, `mem_exc_cause` and `mem_exc_pc` are registered: they are presented the cycle after detection, for one cycle only.
- Reset during WAIT: the request is abandoned. The memory side must tolerate a dropped request.
- `dm_ack` without `dm_req` is ignored.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - Misaligned means a word access with addr[1:0]≠0, or a half access with addr[0]=1.
  - A misaligned access suppresses `dm_req`, produces no stall, inserts a bubble, and pulses `mem_exc` with cause 01 or 10.
- Undefined:
  - `misaligned_trap=0`.
  - Word accesses ignore addr[1:0].
  - Half accesses ignore addr[0].
  - The access proceeds normally on the aligned lanes.

## Test plan
- lw at 0x100, ack in the same cycle, rdata 0xDEADBEEF, rd=5 → no stall; next cycle `wb_valid=1`, `wb_rd=5`, `wb_data=0xDEADBEEF`.
- lb at 0x103, rdata 0x80112233, ack after 3 waits → `stall_mem` high for 3 cycles, then `wb_data=0xFFFFFF80`. Repeat with lbu: `wb_data=0x00000080`.
- sh of 0x0000ABCD at 0x202 → `dm_be=1100`, `dm_wdata[31:16]=0xABCD`, `dm_addr=0x200`, `dm_we=1`.
- Hold ack low for 255 cycles on lw with pc=0x40 → req drops at cycle 255; `mem_exc=1`, cause 11, `mem_exc_pc=0x40`; bubble in MEM/WB.
- lw at 0x101 with `MEM_MISALIGN_TRAP_EN`: no req, cause 01, bubble. Without the macro: `dm_addr=0x100`, normal load.
- Assert `rstn=0` in WAIT → `dm_req=0` immediately, all `wb_*`=0. After release, jal with pc=0x80 → `wb_data=0x84`.
